led_scan_mux: RTL and testbench

Parametrised multi-digit time-multiplexed LED / 7-segment driver. It is the next-generation replacement for the fixed 4-digit FPGA-board scanner. It adds:
- configurable digit count, segment width and refresh prescaler
- per-digit enable
- 16-level PWM brightness
- an anti-ghosting blank phase
- frame-coherent shadowing of display data
- lamp test

It sits between the MIPS FPGA top-level display logic and the board's digit-select and segment pins.

---
 rtl/led_pkg.sv | 26 ++
 rtl/led_tick_gen.sv | 33 +++
 rtl/led_scan_mux.sv | 112 +++++++++++
 tb/tb_led_scan_mux.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_pkg : shared constants and width helpers for the LED scan blocks.  Rev 1.0
// ---------------------------------------------------------------------------
package led_pkg;

  localparam int PHASE_W      = 4;
  localparam int SLOTS_PHASES = 16;

  localparam bit POL_ACTIVE_HIGH = 1'b0;
  localparam bit POL_ACTIVE_LOW  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction

  // Counter/index width that stays at least one bit wide for degenerate sizes.
  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_tick_gen : free-running prescaler, one-cycle tick every CLK_DIV clocks.  Rev 1.0
// ---------------------------------------------------------------------------
module led_tick_gen
  import led_pkg::*;
#(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int              CNT_W   = idx_width(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  assign tick_o    = (div_cnt_q == CNT_MAX);
  assign div_cnt_d = tick_o ? '0 : div_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_scan_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_scan_mux : multiplexed LED/7-seg driver with PWM, dead time and shadowing.  Rev 1.0
// ---------------------------------------------------------------------------
module led_scan_mux
  import led_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SEG_W          = 8,
  parameter int CLK_DIV        = 1000,
  parameter bit SEL_ACTIVE_LOW = POL_ACTIVE_LOW,
  parameter bit SEG_ACTIVE_LOW = POL_ACTIVE_HIGH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_data_i,
  input  logic [NUM_DIGITS-1:0]       dig_en_i,
  input  logic [PHASE_W-1:0]          brightness_i,
  input  logic                        lamp_test_i,
  output logic [NUM_DIGITS-1:0]       sel_o,
  output logic [SEG_W-1:0]            seg_o,
  output logic                        frame_tick_o
);

  localparam int                  IDX_W      = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0]    IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PHASE_W-1:0]  PHASE_LAST = PHASE_W'(SLOTS_PHASES - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = {NUM_DIGITS{SEL_ACTIVE_LOW}};
  localparam logic [SEG_W-1:0]    SEG_IDLE   = {SEG_W{SEG_ACTIVE_LOW}};

  logic                        tick;
  logic                        frame_end;
  logic                        drive;
  logic                        digit_en;
  logic [NUM_DIGITS-1:0]       onehot;
  logic [SEG_W-1:0]            digit_pat;

  logic [PHASE_W-1:0]          phase_q, phase_d;
  logic [IDX_W-1:0]            index_q, index_d;
  logic [NUM_DIGITS*SEG_W-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]       sel_q, sel_d;
  logic [SEG_W-1:0]            seg_q, seg_d;
  logic                        frame_tick_q, frame_tick_d;

  led_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  assign frame_end = tick && (phase_q == PHASE_LAST) && (index_q == IDX_LAST);

  always_comb begin
    phase_d = phase_q;
    index_d = index_q;
    if (tick) begin
      phase_d = phase_q + PHASE_W'(1);
      if (phase_q == PHASE_LAST) begin
        index_d = (index_q == IDX_LAST) ? '0 : index_q + IDX_W'(1);
      end
    end
  end

  // Latch new patterns only at the frame boundary so a frame never tears.
  assign shadow_d     = frame_end ? seg_data_i : shadow_q;
  assign frame_tick_d = frame_end;

  always_comb begin
    onehot    = '0;
    digit_pat = '0;
    digit_en  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (index_q == IDX_W'(k)) begin
        onehot[k] = 1'b1;
        digit_pat = shadow_q[k*SEG_W +: SEG_W];
        digit_en  = dig_en_i[k];
      end
    end
  end

  // Phase 0 of every slot is the dead-time gap between neighbouring digits.
  assign drive = digit_en && (phase_q != '0) && (phase_q <= brightness_i);

  assign sel_d = drive ? (onehot ^ SEL_IDLE) : SEL_IDLE;
  assign seg_d = (drive ? (lamp_test_i ? {SEG_W{1'b1}} : digit_pat) : '0) ^ SEG_IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q      <= '0;
      index_q      <= '0;
      shadow_q     <= '0;
      sel_q        <= SEL_IDLE;
      seg_q        <= SEG_IDLE;
      frame_tick_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      index_q      <= index_d;
      shadow_q     <= shadow_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign sel_o        = sel_q;
  assign seg_o        = seg_q;
  assign frame_tick_o = frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_led_scan_mux.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_led_scan_mux : self-checking bench for a 4-digit and a 5-digit scanner.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_led_scan_mux;

  localparam int CD   = 4;
  localparam int SLOT = 16 * CD;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] seg_data4 = 32'h0;
  logic [39:0] seg_data5 = 40'h0;
  logic [3:0]  dig_en4   = 4'h0;
  logic [4:0]  dig_en5   = 5'h0;
  logic [3:0]  bright    = 4'h0;
  logic        lamp      = 1'b0;

  logic [3:0] sel4;
  logic [7:0] seg4;
  logic       ft4;
  logic [4:0] sel5;
  logic [7:0] seg5;
  logic       ft5;

  always #5 clk = ~clk;

  led_scan_mux #(.NUM_DIGITS(4), .SEG_W(8), .CLK_DIV(CD), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut4 (
    .clk(clk), .rst_n(rst_n), .seg_data_i(seg_data4), .dig_en_i(dig_en4), .brightness_i(bright),
    .lamp_test_i(lamp), .sel_o(sel4), .seg_o(seg4), .frame_tick_o(ft4));

  led_scan_mux #(.NUM_DIGITS(5), .SEG_W(8), .CLK_DIV(CD), .SEL_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut5 (
    .clk(clk), .rst_n(rst_n), .seg_data_i(seg_data5), .dig_en_i(dig_en5), .brightness_i(bright),
    .lamp_test_i(lamp), .sel_o(sel5), .seg_o(seg5), .frame_tick_o(ft5));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: clocks elapsed since reset release plus the latched frame data.
  int          c       = 0;
  int          shown_c = -1;
  logic [31:0] sh4     = 32'h0;
  logic [39:0] sh5     = 40'h0;
  int          prev_act4 = -1;
  int          prev_act5 = -1;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  en;
    logic [3:0]  b;
    logic        lt;
    logic [31:0] on_clk;
    logic [31:0] segs;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the state reached cc clocks after reset release.
  function automatic void model(input int n, input int cc, input logic [39:0] sh, input logic [4:0] en,
                                input logic [3:0] b, input logic lt,
                                output logic [4:0] es, output logic [7:0] eg, output logic fe);
    int ph;
    int dig;
    bit drv;
    ph  = (cc / CD) % 16;
    dig = (cc / SLOT) % n;
    drv = en[dig] && (ph != 0) && (ph <= int'(b));
    es  = 5'h1F;
    eg  = 8'h00;
    if (drv) begin
      es[dig] = 1'b0;
      eg      = lt ? 8'hFF : sh[dig*8 +: 8];
    end
    fe = (cc % (SLOT * n)) == (SLOT * n - 1);
  endfunction

  function automatic int active_digit(input logic [4:0] s);
    int cnt;
    int idx;
    cnt = 0;
    idx = -1;
    for (int k = 0; k < 5; k++) begin
      if (s[k] !== 1'b1) begin
        cnt++;
        idx = k;
      end
    end
    return (cnt > 1) ? -2 : idx;
  endfunction

  // One clock: predict, advance, compare both DUTs and the scan invariants.
  task automatic tick();
    logic [4:0] es4, es5;
    logic [7:0] eg4, eg5;
    logic       fe4, fe5;
    int         a4, a5;
    if (rst_n) begin
      model(4, c, {8'h0, sh4}, {1'b0, dig_en4}, bright, lamp, es4, eg4, fe4);
      model(5, c, sh5, dig_en5, bright, lamp, es5, eg5, fe5);
      shown_c = c;
    end else begin
      es4 = 5'h1F; es5 = 5'h1F; eg4 = 8'h0; eg5 = 8'h0; fe4 = 1'b0; fe5 = 1'b0;
      shown_c = -1;
    end
    @(posedge clk);
    if (rst_n) begin
      if (fe4) sh4 = seg_data4;
      if (fe5) sh5 = seg_data5;
      c++;
    end else begin
      c = 0; sh4 = 32'h0; sh5 = 40'h0;
    end
    #1;
    chk("sel4", sel4, es4[3:0]);
    chk("seg4", seg4, eg4);
    chk("ft4", ft4, fe4);
    chk("sel5", sel5, es5);
    chk("seg5", seg5, eg5);
    chk("ft5", ft5, fe5);
    a4 = active_digit({1'b1, sel4});
    a5 = active_digit(sel5);
    chk("onehot4", (a4 >= -1), 1'b1);
    chk("onehot5", (a5 >= -1), 1'b1);
    chk("deadtime4", (a4 >= 0 && prev_act4 >= 0 && a4 != prev_act4), 1'b0);
    chk("deadtime5", (a5 >= 0 && prev_act5 >= 0 && a5 != prev_act5), 1'b0);
    prev_act4 = a4;
    prev_act5 = a5;
    @(negedge clk);
  endtask

  task automatic wait_state(input int d, input int ph);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (shown_c >= 0 && (shown_c / CD) % 16 == ph && (shown_c / SLOT) % 4 == d) found = 1'b1;
    end
    chk("wait_state_timeout", found, 1'b1);
  endtask

  task automatic wait_ft4();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      tick();
      if (ft4) found = 1'b1;
    end
    chk("wait_ft4_timeout", found, 1'b1);
  endtask

  initial begin
    int first_ft, nz, t4a, t4b, t5a, t5b, lat;
    int cnt [4];
    logic [7:0] segv [4];

    tbl[0] = '{32'h44332211, 4'hF, 4'd15, 1'b0, 32'h3C3C3C3C, 32'h44332211};
    tbl[1] = '{32'h44332211, 4'hF, 4'd3,  1'b0, 32'h0C0C0C0C, 32'h44332211};
    tbl[2] = '{32'h44332211, 4'hF, 4'd0,  1'b0, 32'h00000000, 32'h00000000};
    tbl[3] = '{32'h44332211, 4'hF, 4'd0,  1'b0, 32'h00000000, 32'h00000000};
    tbl[4] = '{32'h44332211, 4'h5, 4'd15, 1'b1, 32'h003C003C, 32'h00FF00FF};
    tbl[5] = '{32'h88776655, 4'hA, 4'd8,  1'b0, 32'h20002000, 32'h88006600};

    // Reset values
    seg_data4 = 32'h44332211;
    seg_data5 = 40'h5544332211;
    bright    = 4'd15;
    dig_en4   = 4'hF;
    dig_en5   = 5'h1F;
    #2 rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    chk("reset_sel", sel4, 4'b1111);
    chk("reset_seg", seg4, 8'h00);
    chk("reset_ft", ft4, 1'b0);
    rst_n = 1'b1;

    // Frame 0 is blank; first frame_tick after 256 clocks
    first_ft = -1;
    nz = 0;
    for (int i = 1; i <= 260; i++) begin
      tick();
      if (i <= 256 && seg4 != 8'h00) nz++;
      if (ft4 && first_ft < 0) first_ft = i;
    end
    chk("blank_frame0", nz, 0);
    chk("first_ft", first_ft, 256);

    // frame_tick periods for 4 and 5 digits
    t4a = -1; t4b = -1; t5a = -1; t5b = -1;
    for (int i = 0; i < 1400 && (t4b < 0 || t5b < 0); i++) begin
      tick();
      if (ft4) begin if (t4a < 0) t4a = i; else if (t4b < 0) t4b = i; end
      if (ft5) begin if (t5a < 0) t5a = i; else if (t5b < 0) t5b = i; end
    end
    chk("period4", t4b - t4a, 256);
    chk("period5", t5b - t5a, 320);

    // Table-driven frames: on-time and displayed pattern per digit
    for (int v = 0; v < 6; v++) begin
      seg_data4 = tbl[v].data;
      dig_en4   = tbl[v].en;
      bright    = tbl[v].b;
      lamp      = tbl[v].lt;
      wait_ft4();
      for (int k = 0; k < 4; k++) begin cnt[k] = 0; segv[k] = 8'h00; end
      for (int i = 0; i < 256; i++) begin
        int a;
        tick();
        a = active_digit({1'b1, sel4});
        if (a >= 0) begin cnt[a]++; segv[a] = seg4; end
      end
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("vec%0d_on_clk_d%0d", v, k), cnt[k], tbl[v].on_clk[k*8 +: 8]);
        chk($sformatf("vec%0d_seg_d%0d", v, k), segv[k], tbl[v].segs[k*8 +: 8]);
      end
    end

    // Frame coherence: mid-frame data change shows only from the next frame
    seg_data4 = 32'h44332211;
    dig_en4   = 4'hF;
    bright    = 4'd15;
    lamp      = 1'b0;
    wait_ft4();
    wait_state(1, 8);
    seg_data4 = 32'hDDCCBBAA;
    wait_state(2, 5); chk("coh_d2_old", seg4, 8'h33);
    wait_state(3, 5); chk("coh_d3_old", seg4, 8'h44);
    wait_state(0, 5); chk("coh_d0_new", seg4, 8'hAA);
    wait_state(1, 5); chk("coh_d1_new", seg4, 8'hBB);
    wait_state(2, 5); chk("coh_d2_new", seg4, 8'hCC);
    wait_state(3, 5); chk("coh_d3_new", seg4, 8'hDD);

    // Randomised inputs over 20 frames against the reference model
    for (int i = 0; i < 20 * 256; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        bright    = 4'($urandom_range(0, 15));
        dig_en4   = 4'($urandom);
        dig_en5   = 5'($urandom);
        lamp      = ($urandom_range(0, 7) == 0);
        seg_data4 = $urandom;
        seg_data5 = {8'($urandom), 32'($urandom)};
      end
      tick();
    end

    // Asynchronous reset during the digit-2 on-phase
    bright  = 4'd15;
    dig_en4 = 4'hF;
    dig_en5 = 5'h1F;
    lamp    = 1'b0;
    wait_state(2, 6);
    chk("pre_reset_active", sel4, 4'b1011);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sel4", sel4, 4'b1111);
    chk("async_seg4", seg4, 8'h00);
    chk("async_sel5", sel5, 5'b11111);
    tick();
    tick();
    rst_n = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      tick();
      if (sel4 != 4'b1111) lat = i;
    end
    chk("restart_latency", lat, 5);
    chk("restart_digit0", sel4, 4'b1110);
    for (int i = 0; i < 2 * 320; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
